// File: rtl/decode_execute_buffer.sv
// Decode-to-execute pipeline register with write-back bypass and load-use bubble insertion.
// Optional build macro ZERO_REG_EN makes r0 a hardwired zero register.
module decode_execute_buffer #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 3,
    parameter int OPC_W        = 5,
    parameter int LOAD_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_uses_rs1,
    input  logic              in_uses_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic              wb_write_enable,
    input  logic [ADDR_W-1:0] wb_write_addr,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              dec_stall,
    output logic              out_valid,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [ADDR_W-1:0] out_rs1,
    output logic [ADDR_W-1:0] out_rs2,
    output logic [ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_imm
);

    localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_BUBBLES - 1);

    logic [1:0]        bcnt;
    logic              haz;
    logic              rd_live;
    logic              reg_write_p0;
    logic              mem_read_p0;
    logic [DATA_W-1:0] op1_p0;
    logic [DATA_W-1:0] op2_p0;

    // The regfile commits its write after this edge, so a matching write-back must win over read data.
    function automatic logic [DATA_W-1:0] bypass(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rdata,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] v;
        v = (we && (waddr == src)) ? wdata : rdata;
`ifdef ZERO_REG_EN
        if (src == '0) v = '0;
`endif
        return v;
    endfunction

    // Stage p0: decode-side operand selection and hazard detection
    always_comb begin
        op1_p0      = bypass(in_rs1, read_data1, wb_write_enable, wb_write_addr, wb_write_data);
        op2_p0      = bypass(in_rs2, read_data2, wb_write_enable, wb_write_addr, wb_write_data);
        mem_read_p0 = in_valid & in_mem_read;
`ifdef ZERO_REG_EN
        reg_write_p0 = in_valid & in_reg_write & (in_rd != '0);
        rd_live      = (out_rd != '0);
`else
        reg_write_p0 = in_valid & in_reg_write;
        rd_live      = 1'b1;
`endif
        haz = in_valid & out_valid & out_mem_read & out_reg_write & rd_live &
              ((in_uses_rs1 & (in_rs1 == out_rd)) | (in_uses_rs2 & (in_rs2 == out_rd)));
        dec_stall = !rst & (ex_stall | haz | (bcnt != 2'd0));
    end

    // Stage p1: D/E register, priority rst > flush > ex_stall > bubble > load
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt          <= 2'd0;
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
            out_opcode    <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_op1       <= '0;
            out_op2       <= '0;
            out_imm       <= '0;
        end else if (flush) begin
            bcnt          <= 2'd0;
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else if (ex_stall) begin
            bcnt <= bcnt;
        end else if (bcnt != 2'd0) begin
            bcnt          <= bcnt - 2'd1;
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else if (haz) begin
            bcnt          <= BUBBLE_RELOAD;
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_read  <= 1'b0;
        end else begin
            out_valid     <= in_valid;
            out_reg_write <= reg_write_p0;
            out_mem_read  <= mem_read_p0;
            out_opcode    <= in_opcode;
            out_rs1       <= in_rs1;
            out_rs2       <= in_rs2;
            out_rd        <= in_rd;
            out_op1       <= op1_p0;
            out_op2       <= op2_p0;
            out_imm       <= in_imm;
        end
    end

endmodule

// File: tb/tb_decode_execute_buffer.sv
// Bench for decode_execute_buffer: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the D/E buffer.
module tb_decode_execute_buffer;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int OW = 5;
    localparam int LB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_uses_rs1, in_uses_rs2, in_reg_write, in_mem_read;
    logic [OW-1:0] in_opcode;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [DW-1:0] in_imm, read_data1, read_data2;
    logic          wb_write_enable;
    logic [AW-1:0] wb_write_addr;
    logic [DW-1:0] wb_write_data;
    logic          flush, ex_stall;
    logic          dec_stall, out_valid, out_reg_write, out_mem_read;
    logic [OW-1:0] out_opcode;
    logic [AW-1:0] out_rs1, out_rs2, out_rd;
    logic [DW-1:0] out_op1, out_op2, out_imm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_execute_buffer #(.DATA_W(DW), .ADDR_W(AW), .OPC_W(OW), .LOAD_BUBBLES(LB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_imm(in_imm),
        .read_data1(read_data1), .read_data2(read_data2),
        .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .flush(flush), .ex_stall(ex_stall), .dec_stall(dec_stall),
        .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_opcode(out_opcode), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: what E must hold, plus how many forced bubbles remain.
    logic          m_armed = 1'b0;
    logic          m_known;
    logic          e_valid, e_rw, e_mr;
    logic [OW-1:0] e_opc;
    logic [AW-1:0] e_rs1, e_rs2, e_rd;
    logic [DW-1:0] e_op1, e_op2, e_imm;
    int            m_bubbles;

    // Value register src will hold once the write-back in flight this cycle lands.
    function automatic logic [DW-1:0] reg_value(input logic [AW-1:0] src, input logic [DW-1:0] rdata);
`ifdef ZERO_REG_EN
        if (src == 0) return 16'h0000;
`endif
        if (wb_write_enable && wb_write_addr == src) return wb_write_data;
        return rdata;
    endfunction

    function automatic logic writes_rd(input logic [AW-1:0] rd, input logic rw);
`ifdef ZERO_REG_EN
        if (rd == 0) return 1'b0;
`endif
        return rw;
    endfunction

    // A load sitting in E whose destination the decoding instruction needs.
    function automatic logic load_use();
        logic needs;
        needs = (in_uses_rs1 && in_rs1 == e_rd) || (in_uses_rs2 && in_rs2 == e_rd);
`ifdef ZERO_REG_EN
        if (e_rd == 0) needs = 1'b0;
`endif
        return in_valid && e_valid && e_mr && e_rw && needs;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_armed = 1'b1; m_known = 1'b1; m_bubbles = 0;
            e_valid = 0; e_rw = 0; e_mr = 0; e_opc = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0;
            e_op1 = 0; e_op2 = 0; e_imm = 0;
        end else if (m_armed) begin
            if (flush) begin
                e_valid = 0; e_rw = 0; e_mr = 0; m_bubbles = 0; m_known = 1'b0;
            end else if (ex_stall) begin
                m_known = m_known;
            end else if (m_bubbles > 0 || load_use()) begin
                m_bubbles = (m_bubbles > 0) ? m_bubbles - 1 : LB - 1;
                e_valid = 0; e_rw = 0; e_mr = 0; m_known = 1'b0;
            end else begin
                e_valid = in_valid;
                e_rw    = in_valid && writes_rd(in_rd, in_reg_write);
                e_mr    = in_valid && in_mem_read;
                e_opc = in_opcode; e_rs1 = in_rs1; e_rs2 = in_rs2; e_rd = in_rd; e_imm = in_imm;
                e_op1 = reg_value(in_rs1, read_data1);
                e_op2 = reg_value(in_rs2, read_data2);
                m_known = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            chk("m_dec_stall", 32'(dec_stall), 32'(!rst && (ex_stall || load_use() || m_bubbles != 0)));
            chk("m_valid", 32'(out_valid), 32'(e_valid));
            chk("m_reg_write", 32'(out_reg_write), 32'(e_rw));
            chk("m_mem_read", 32'(out_mem_read), 32'(e_mr));
            if (m_known) begin
                chk("m_opcode", 32'(out_opcode), 32'(e_opc));
                chk("m_rs1", 32'(out_rs1), 32'(e_rs1));
                chk("m_rs2", 32'(out_rs2), 32'(e_rs2));
                chk("m_rd", 32'(out_rd), 32'(e_rd));
                chk("m_op1", 32'(out_op1), 32'(e_op1));
                chk("m_op2", 32'(out_op2), 32'(e_op2));
                chk("m_imm", 32'(out_imm), 32'(e_imm));
            end
        end
    end

    task automatic idle();
        in_valid = 0; in_opcode = 0; in_rs1 = 0; in_rs2 = 0; in_uses_rs1 = 0; in_uses_rs2 = 0;
        in_rd = 0; in_reg_write = 0; in_mem_read = 0; in_imm = 0; read_data1 = 0; read_data2 = 0;
        wb_write_enable = 0; wb_write_addr = 0; wb_write_data = 0; flush = 0; ex_stall = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        in_valid = 1; in_opcode = 5'h1f; in_rs1 = 7; in_rs2 = 7; in_uses_rs1 = 1; in_uses_rs2 = 1;
        in_rd = 7; in_reg_write = 1; in_mem_read = 1; in_imm = 16'hDEAD;
        read_data1 = 16'hFFFF; read_data2 = 16'hAAAA; ex_stall = 1;
        #1 chk("rst_dec_stall_pre", 32'(dec_stall), 32'd0);
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_reg_write", 32'(out_reg_write), 32'd0);
        chk("rst_mem_read", 32'(out_mem_read), 32'd0);
        chk("rst_op1", 32'(out_op1), 32'd0);
        chk("rst_imm", 32'(out_imm), 32'd0);
        chk("rst_dec_stall", 32'(dec_stall), 32'd0);
        rst = 0;

        idle(); in_valid = 1; in_opcode = 3; in_rs1 = 2; in_uses_rs1 = 1; read_data1 = 16'h1234;
        in_rd = 1; in_reg_write = 1;
        tick();
        chk("first_op1", 32'(out_op1), 32'h1234);
        chk("first_valid", 32'(out_valid), 32'd1);

        in_rs1 = 6; read_data1 = 16'h1111; in_rs2 = 3; in_uses_rs2 = 1; read_data2 = 16'h0000;
        wb_write_enable = 1; wb_write_addr = 3; wb_write_data = 16'hBEEF;
        tick();
        chk("bypass_op2", 32'(out_op2), 32'hBEEF);
        chk("nobypass_op1", 32'(out_op1), 32'h1111);

        // Load to r5, then a consumer of r5: two bubbles, then bypassed issue.
        idle(); in_valid = 1; in_opcode = 8; in_rs1 = 1; in_uses_rs1 = 1; read_data1 = 16'h0010;
        in_rd = 5; in_reg_write = 1; in_mem_read = 1; in_imm = 4;
        tick();
        chk("load_mem_read", 32'(out_mem_read), 32'd1);
        idle(); in_valid = 1; in_opcode = 2; in_rs1 = 5; in_uses_rs1 = 1; in_rd = 2; in_reg_write = 1;
        #1 chk("lu_stall_0", 32'(dec_stall), 32'd1);
        tick();
        chk("lu_bubble1_valid", 32'(out_valid), 32'd0);
        chk("lu_bubble1_rw", 32'(out_reg_write), 32'd0);
        chk("lu_stall_1", 32'(dec_stall), 32'd1);
        tick();
        chk("lu_bubble2_valid", 32'(out_valid), 32'd0);
        chk("lu_stall_2", 32'(dec_stall), 32'd0);
        wb_write_enable = 1; wb_write_addr = 5; wb_write_data = 16'hCAFE;
        tick();
        chk("lu_issue_valid", 32'(out_valid), 32'd1);
        chk("lu_issue_op1", 32'(out_op1), 32'hCAFE);
        chk("lu_issue_rd", 32'(out_rd), 32'd2);

        // Flush on a hazard cycle leaves no pending bubbles.
        idle(); in_valid = 1; in_opcode = 8; in_rd = 4; in_reg_write = 1; in_mem_read = 1;
        tick();
        idle(); in_valid = 1; in_opcode = 9; in_rs2 = 4; in_uses_rs2 = 1; read_data2 = 16'h0044;
        in_rd = 6; in_reg_write = 1; flush = 1;
        #1 chk("fl_stall_pre", 32'(dec_stall), 32'd1);
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_mem_read", 32'(out_mem_read), 32'd0);
        flush = 0;
        #1 chk("fl_stall_post", 32'(dec_stall), 32'd0);
        tick();
        chk("fl_reissue_op2", 32'(out_op2), 32'h0044);
        chk("fl_reissue_opc", 32'(out_opcode), 32'd9);

        // ex_stall freezes E for three cycles while decode keeps changing.
        for (int k = 0; k < 3; k++) begin
            idle(); in_valid = 1; in_opcode = 5'(10 + k); in_rd = 3'(k); in_rs2 = 3'(k);
            read_data2 = 16'(16'h0100 * k); in_mem_read = 1; ex_stall = 1;
            #1 chk("xs_stall", 32'(dec_stall), 32'd1);
            tick();
            chk("xs_opcode", 32'(out_opcode), 32'd9);
            chk("xs_rd", 32'(out_rd), 32'd6);
            chk("xs_op2", 32'(out_op2), 32'h0044);
            chk("xs_mem_read", 32'(out_mem_read), 32'd0);
        end
        idle(); in_valid = 1; in_opcode = 5'h14; in_rs1 = 2; in_uses_rs1 = 1; read_data1 = 16'h5555; in_rd = 3;
        tick();
        chk("xs_release_opc", 32'(out_opcode), 32'h14);
        chk("xs_release_op1", 32'(out_op1), 32'h5555);

        // Reset in the middle of a bubble sequence.
        idle(); in_valid = 1; in_opcode = 8; in_rd = 5; in_reg_write = 1; in_mem_read = 1;
        tick();
        idle(); in_valid = 1; in_rs1 = 5; in_uses_rs1 = 1; in_rd = 1; in_reg_write = 1;
        tick();
        chk("rb_stall_mid", 32'(dec_stall), 32'd1);
        rst = 1;
        #1 chk("rb_stall_in_rst", 32'(dec_stall), 32'd0);
        tick();
        rst = 0;
        #1 chk("rb_stall_after", 32'(dec_stall), 32'd0);
        chk("rb_valid", 32'(out_valid), 32'd0);

        // r0 behaviour depends on the build.
        idle(); in_valid = 1; in_opcode = 1; in_rs1 = 0; in_uses_rs1 = 1; read_data1 = 16'hFFFF;
        in_rd = 0; in_reg_write = 1; wb_write_enable = 1; wb_write_addr = 0; wb_write_data = 16'h7777;
        tick();
`ifdef ZERO_REG_EN
        chk("r0_op1", 32'(out_op1), 32'h0000);
        chk("r0_reg_write", 32'(out_reg_write), 32'd0);
`else
        chk("r0_op1", 32'(out_op1), 32'h7777);
        chk("r0_reg_write", 32'(out_reg_write), 32'd1);
`endif

        // Mixed traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 60; i++) begin
            in_valid = (i % 5) != 4; in_opcode = 5'(i);
            in_rs1 = 3'(i % 8); in_rs2 = 3'((i * 3) % 8);
            in_uses_rs1 = 1'((i / 2) % 2); in_uses_rs2 = 1'((i / 3) % 2);
            in_rd = 3'((i * 5) % 8); in_reg_write = (i % 3) != 0; in_mem_read = (i % 4) == 1;
            in_imm = 16'(i * 16'h0111); read_data1 = 16'(i * 16'h0101); read_data2 = 16'(16'hF0F0 ^ i);
            wb_write_enable = 1'(i % 2); wb_write_addr = 3'((i * 7) % 8); wb_write_data = 16'(16'hA000 + i);
            flush = (i % 11) == 10; ex_stall = (i % 7) == 6;
            tick();
        end
        idle();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
